// File: rtl/fpadd_sched.sv
// rtl/fpadd_sched.sv - round-robin scheduler sharing one multi-cycle fpadd unit
// Grants one requester at a time, drives the adder and returns its result or a timeout.
module fpadd_sched #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_dataa,
   input  logic [N_REQ*WIDTH-1:0] req_datab,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]       resp_result,
   output logic                   resp_err,
   output logic                   busy,
   output logic                   add_reset,
   output logic [WIDTH-1:0]       add_dataa,
   output logic [WIDTH-1:0]       add_datab,
   input  logic [WIDTH-1:0]       add_result,
   input  logic                   add_done
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7fc00000);

   logic [1:0]       r_state;
   logic [IW-1:0]    r_rr;
   logic [IW-1:0]    r_grant;
   logic [WIDTH-1:0] r_dataa;
   logic [WIDTH-1:0] r_datab;
   logic [WIDTH-1:0] r_result;
   logic             r_err;
   logic [CW-1:0]    r_cnt;

   logic             w_found;
   logic [IW-1:0]    w_pick;
   logic [IW:0]      w_cand;
   logic [IW:0]      w_next;

   // First pending request at or above the rr pointer, wrapping at N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = {1'b0, r_rr} + (IW+1)'(k);
         if (w_cand >= (IW+1)'(N_REQ))
            w_cand = w_cand - (IW+1)'(N_REQ);
         if (!w_found && req_valid[w_cand[IW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_cand[IW-1:0];
         end
      end
   end

   always_comb begin
      w_next = {1'b0, r_grant} + (IW+1)'(1);
      if (w_next >= (IW+1)'(N_REQ))
         w_next = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_rr     <= '0;
         r_grant  <= '0;
         r_dataa  <= '0;
         r_datab  <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_pick;
                  r_dataa <= req_dataa[w_pick*WIDTH +: WIDTH];
                  r_datab <= req_datab[w_pick*WIDTH +: WIDTH];
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (add_done) begin
                  r_result <= add_result;
                  r_err    <= 1'b0;
                  r_state  <= S_RESP;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_result <= QNAN;
                  r_err    <= 1'b1;
                  r_state  <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_rr    <= w_next[IW-1:0];
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      resp_valid = '0;
      if (r_state == S_RESP)
         resp_valid[r_grant] = 1'b1;
   end

   // The adder is held in reset everywhere but WAIT, so its done is only seen there.
   assign add_reset   = (r_state != S_WAIT);
   assign busy        = (r_state != S_IDLE);
   assign add_dataa   = r_dataa;
   assign add_datab   = r_datab;
   assign resp_result = r_result;
   assign resp_err    = r_err;

endmodule

// File: tb/tb_fpadd_sched.sv
// tb/tb_fpadd_sched.sv - self-checking bench for fpadd_sched with a behavioural fpadd
// Expected responses are queued at request time and popped when resp_valid pulses.
module tb_fpadd_sched;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int LAT = 3;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_dataa;
   logic [N*W-1:0] req_datab;
   logic [N-1:0]   resp_valid;
   logic [W-1:0]   resp_result;
   logic           resp_err;
   logic           busy;
   logic           add_reset;
   logic [W-1:0]   add_dataa;
   logic [W-1:0]   add_datab;
   logic [W-1:0]   add_result;
   logic           add_done;

   fpadd_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
      .req_dataa(req_dataa), .req_datab(req_datab),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
      .busy(busy), .add_reset(add_reset), .add_dataa(add_dataa),
      .add_datab(add_datab), .add_result(add_result), .add_done(add_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t vt[4];
   int   checks = 0;
   int   errors = 0;
   int   hold_cnt[N];
   int   resp_cnt[N];
   int   start_cycles = 0;
   int   wait_run = 0;
   int   wait_len = 0;
   int   acnt = 0;
   bit   stuck = 1'b0;

   function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3fc00000, 32'h3fa00000}: return 32'h40300000;
         {32'h3fc00000, 32'hbfa00000}: return 32'h3e800000;
         {32'h3d800000, 32'h3f800000}: return 32'h3f880000;
         {32'hbf800000, 32'h3f800000}: return 32'h00000000;
         default:                      return a ^ b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural fpadd: done LAT cycles after reset is released, unless stuck.
   always @(negedge clk) begin
      if (add_reset) begin
         acnt       = 0;
         add_done   = 1'b0;
         add_result = '0;
      end else begin
         acnt++;
         if (!stuck && acnt >= LAT) begin
            add_done   = 1'b1;
            add_result = lookup(add_dataa, add_datab);
         end
      end
   end

   always @(negedge clk) begin
      int   ridx;
      exp_t e;
      if (busy && add_reset && resp_valid == '0)
         start_cycles++;
      if (busy && !add_reset) begin
         wait_run++;
      end else if (wait_run != 0) begin
         wait_len = wait_run;
         wait_run = 0;
      end
      if (resp_valid != '0) begin
         ridx = -1;
         check("resp_onehot", 32'($countones(resp_valid)), 32'd1);
         for (int i = 0; i < N; i++) begin
            if (resp_valid[i]) begin
               ridx = i;
               resp_cnt[i]++;
               if (hold_cnt[i] > 1) begin
                  hold_cnt[i]--;
               end else begin
                  hold_cnt[i]  = 0;
                  req_valid[i] = 1'b0;
               end
            end
         end
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid %b expected none", resp_valid);
         end else begin
            e = sb.pop_front();
            check("resp_idx", ridx, e.idx);
            check("resp_result", resp_result, e.res);
            check("resp_err", 32'(resp_err), 32'(e.err));
         end
      end
   end

   task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
      req_dataa[idx*W +: W] = a;
      req_datab[idx*W +: W] = b;
   endtask

   task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sum);
      set_ops(idx, a, b);
      hold_cnt[idx]  = 1;
      req_valid[idx] = 1'b1;
      sb.push_back('{idx: idx, res: sum, err: 1'b0});
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_drain: got %0d responses outstanding expected 0", name, sb.size());
      end
   endtask

   task automatic wait_in_wait(input string name);
      int n = 0;
      while (add_reset && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reach_wait"}, 32'(add_reset), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      req_valid  = '0;
      req_dataa  = '0;
      req_datab  = '0;
      add_done   = 1'b0;
      add_result = '0;
      for (int i = 0; i < N; i++) begin
         hold_cnt[i] = 1;
         resp_cnt[i] = 0;
      end
      vt[0] = '{idx: 0, a: 32'h3fc00000, b: 32'h3fa00000, sum: 32'h40300000};
      vt[1] = '{idx: 1, a: 32'h3d800000, b: 32'h3f800000, sum: 32'h3f880000};
      vt[2] = '{idx: 2, a: 32'hbf800000, b: 32'h3f800000, sum: 32'h00000000};
      vt[3] = '{idx: 3, a: 32'h3fc00000, b: 32'hbfa00000, sum: 32'h3e800000};

      repeat (2) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_result", resp_result, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_add_reset", 32'(add_reset), 32'd1);
      check("rst_add_dataa", add_dataa, 32'd0);
      check("rst_add_datab", add_datab, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         start_cycles = 0;
         issue(vt[v].idx, vt[v].a, vt[v].b, vt[v].sum);
         wait_in_wait("vec");
         check("vec_add_dataa", add_dataa, vt[v].a);
         check("vec_add_datab", add_datab, vt[v].b);
         drain("vec");
         check("vec_start_cycles", start_cycles, 32'd1);
         repeat (2) @(negedge clk);
         check("vec_result_hold", resp_result, vt[v].sum);
         check("vec_err_hold", 32'(resp_err), 32'd0);
      end

      do_reset();
      issue(0, 32'h3fc00000, 32'hbfa00000, 32'h3e800000);
      issue(1, 32'h3d800000, 32'h3f800000, 32'h3f880000);
      issue(2, 32'hbf800000, 32'h3f800000, 32'h00000000);
      drain("batch");

      do_reset();
      issue(2, 32'hbf800000, 32'h3f800000, 32'h00000000);
      drain("fair_pre");
      set_ops(3, 32'h3fc00000, 32'h3fa00000);
      set_ops(0, 32'h3d800000, 32'h3f800000);
      sb.push_back('{idx: 3, res: 32'h40300000, err: 1'b0});
      sb.push_back('{idx: 0, res: 32'h3f880000, err: 1'b0});
      sb.push_back('{idx: 3, res: 32'h40300000, err: 1'b0});
      sb.push_back('{idx: 0, res: 32'h3f880000, err: 1'b0});
      hold_cnt[3]  = 2;
      hold_cnt[0]  = 2;
      req_valid[3] = 1'b1;
      req_valid[0] = 1'b1;
      drain("fair");

      do_reset();
      stuck    = 1'b1;
      wait_len = 0;
      set_ops(1, 32'h3fc00000, 32'h3fa00000);
      hold_cnt[1]  = 1;
      req_valid[1] = 1'b1;
      sb.push_back('{idx: 1, res: 32'h7fc00000, err: 1'b1});
      drain("timeout");
      check("timeout_wait_cycles", wait_len, 32'd15);
      stuck = 1'b0;

      do_reset();
      set_ops(2, 32'h3fc00000, 32'h3fa00000);
      hold_cnt[2]  = 1;
      req_valid[2] = 1'b1;
      wait_in_wait("abort");
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = '0;
      #1;
      check("abort_add_reset", 32'(add_reset), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_add_dataa", add_dataa, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      issue(1, 32'h3d800000, 32'h3f800000, 32'h3f880000);
      drain("after_abort");

      resp_cnt[2] = 0;
      issue(2, 32'hbf800000, 32'h3f800000, 32'h00000000);
      wait_in_wait("drop");
      req_valid[2] = 1'b0;
      set_ops(2, 32'h12345678, 32'h0f0f0f0f);
      drain("drop");
      repeat (5) @(negedge clk);
      check("drop_resp_count", resp_cnt[2], 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
